// File: rtl/posit_decoder_param.sv
// Multi-cycle parametrised posit decoder: serial regime scan, start/done/recieved handshake.
// Optional macro POSIT_DEC_SCALE_EN adds a registered combined scale output k*2^ES + exponent.
module posit_decoder_param #(
    parameter  int N  = 32,
    parameter  int ES = 3,
    localparam int KW = $clog2(N) + 1,
    localparam int EW = (ES > 0) ? ES : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         posit_num,
    input  logic                 start,
    input  logic                 recieved,
    output logic                 busy,
    output logic                 done,
    output logic                 sign,
    output logic                 ZERO,
    output logic                 NAR,
    output logic signed [KW-1:0] k,
    output logic [EW-1:0]        exp_value,
    output logic [N-1:0]         mantissa
`ifdef POSIT_DEC_SCALE_EN
    ,
    output logic signed [KW+ES:0] scale
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CONV   = 3'd1;
    localparam logic [2:0] S_REGIME = 3'd2;
    localparam logic [2:0] S_FIELDS = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [N-1:0] NAR_PAT = {1'b1, {(N-1){1'b0}}};

    logic [2:0]           state_q, state_d;
    logic [N-1:0]         work_q, work_d;
    logic [KW-1:0]        m_q, m_d;
    logic                 r_q, r_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sign_q, sign_d;
    logic                 zero_q, zero_d;
    logic                 nar_q, nar_d;
    logic signed [KW-1:0] k_q, k_d;
    logic [EW-1:0]        exp_q, exp_d;
    logic [N-1:0]         mant_q, mant_d;

    logic [N-1:0]         absOp;
    logic [N-1:0]         shiftedOp;
    logic [N-1:0]         fracAligned;
    logic [EW-1:0]        expField;
    logic signed [KW-1:0] kCalc;

    assign absOp       = work_q[N-1] ? (~work_q + N'(1)) : work_q;
    assign shiftedOp   = absOp << 1;
    // After the regime is consumed, the fraction sits ES bits below the top; one more
    // right shift leaves the MSB free for the hidden bit.
    assign fracAligned = (work_q << ES) >> 1;
    assign kCalc       = r_q ? (m_q - KW'(1)) : (KW'(0) - m_q);

    generate
        if (ES > 0) begin : gExp
            assign expField = work_q[N-1 -: EW];
        end else begin : gNoExp
            assign expField = '0;
        end
    endgenerate

`ifdef POSIT_DEC_SCALE_EN
    logic signed [KW+ES:0] scale_q, scale_d;
    logic signed [KW+ES:0] scaleCalc;

    assign scaleCalc = ((KW+ES+1)'(kCalc) <<< ES) + $signed((KW+ES+1)'(expField));
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        m_d     = m_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        nar_d   = nar_q;
        k_d     = k_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
`ifdef POSIT_DEC_SCALE_EN
        scale_d = scale_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = posit_num;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    zero_d  = 1'b0;
                    nar_d   = 1'b0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if ((work_q == '0) || (work_q == NAR_PAT)) begin
                    zero_d  = (work_q == '0);
                    nar_d   = (work_q == NAR_PAT);
                    sign_d  = work_q[N-1];
                    k_d     = '0;
                    exp_d   = '0;
                    mant_d  = '0;
`ifdef POSIT_DEC_SCALE_EN
                    scale_d = '0;
`endif
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    sign_d  = work_q[N-1];
                    work_d  = shiftedOp;
                    r_d     = shiftedOp[N-1];
                    m_d     = '0;
                    state_d = S_REGIME;
                end
            end
            S_REGIME: begin
                // A matching bit extends the run; the first opposite bit is consumed as terminator.
                work_d = work_q << 1;
                if (work_q[N-1] == r_q) begin
                    m_d = m_q + KW'(1);
                    if (m_q == KW'(N-2)) begin
                        state_d = S_FIELDS;
                    end
                end else begin
                    state_d = S_FIELDS;
                end
            end
            S_FIELDS: begin
                k_d     = kCalc;
                exp_d   = expField;
                mant_d  = fracAligned | NAR_PAT;
`ifdef POSIT_DEC_SCALE_EN
                scale_d = scaleCalc;
`endif
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (recieved) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            m_q     <= '0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            nar_q   <= 1'b0;
            k_q     <= '0;
            exp_q   <= '0;
            mant_q  <= '0;
`ifdef POSIT_DEC_SCALE_EN
            scale_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            m_q     <= m_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            nar_q   <= nar_d;
            k_q     <= k_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
`ifdef POSIT_DEC_SCALE_EN
            scale_q <= scale_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sign      = sign_q;
    assign ZERO      = zero_q;
    assign NAR       = nar_q;
    assign k         = k_q;
    assign exp_value = exp_q;
    assign mantissa  = mant_q;
`ifdef POSIT_DEC_SCALE_EN
    assign scale     = scale_q;
`endif

endmodule
